// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// variable-latency memory handshake, BNE, and illegal-opcode trap.
module multicycle_control_fsm #(
    parameter int OPCODE_W = 4,
    parameter int STATE_W  = 5,
    parameter bit TRAP_EN  = 1'b1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                Trap,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          MemToReg,
    output logic [1:0]          PCSrc,
    output logic [STATE_W-1:0]  current_state,
    output logic [STATE_W-1:0]  next_state
);

    localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_R_ADD     = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_R_SUB     = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_R_WB      = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_R_WB_GT   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_R_WB_EQ   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_J_EXEC    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_J_WB      = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_M_ADDR    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_M_ADDI_WB = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_M_LW_RD   = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_M_LW_WB   = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_M_SW      = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_I_BNE     = STATE_W'(14);
    localparam logic [STATE_W-1:0] S_I_IMM     = STATE_W'(15);
    localparam logic [STATE_W-1:0] S_I_WB      = STATE_W'(16);
    localparam logic [STATE_W-1:0] S_TRAP      = STATE_W'(17);

    localparam logic [STATE_W-1:0] S_ILLEGAL = TRAP_EN ? S_TRAP : S_FETCH;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               hi_bits;
    logic [3:0]         op;

    // Any set bit above the 4-bit opcode space marks the instruction illegal.
    assign hi_bits = (Opcode >> 4) != '0;
    assign op      = Opcode[3:0];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:     state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (hi_bits) begin
                    state_d = S_ILLEGAL;
                end else begin
                    case (op)
                        4'd0:                state_d = S_R_ADD;
                        4'd1, 4'd2, 4'd3:    state_d = S_R_SUB;
                        4'd4, 4'd6:          state_d = S_J_EXEC;
                        4'd5, 4'd15:         state_d = S_I_IMM;
                        4'd8, 4'd9, 4'd10:   state_d = S_M_ADDR;
                        4'd11:               state_d = S_I_BNE;
                        default:             state_d = S_ILLEGAL;
                    endcase
                end
            end
            S_R_ADD:     state_d = S_R_WB;
            S_R_SUB: begin
                if (!hi_bits && op == 4'd1)      state_d = S_R_WB_GT;
                else if (!hi_bits && op == 4'd2) state_d = S_R_WB;
                else if (!hi_bits && op == 4'd3) state_d = S_R_WB_EQ;
                else                             state_d = S_FETCH;
            end
            S_J_EXEC: begin
                if (!hi_bits && (op == 4'd4 || op == 4'd6)) state_d = S_J_WB;
                else                                        state_d = S_FETCH;
            end
            S_M_ADDR: begin
                if (!hi_bits && op == 4'd8)       state_d = S_M_ADDI_WB;
                else if (!hi_bits && op == 4'd9)  state_d = S_M_LW_RD;
                else if (!hi_bits && op == 4'd10) state_d = S_M_SW;
                else                              state_d = S_FETCH;
            end
            S_M_LW_RD:   state_d = MemReady ? S_M_LW_WB : S_M_LW_RD;
            S_M_SW:      state_d = MemReady ? S_FETCH : S_M_SW;
            S_I_IMM:     state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        Trap        = 1'b0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        MemToReg    = 2'd0;
        PCSrc       = 2'd0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_R_ADD:  ALUSrcA = 2'd1;
            S_R_SUB: begin
                ALUSrcA = 2'd1;
                ALUOp   = 2'd1;
            end
            S_R_WB:   RegWrite = 1'b1;
            S_R_WB_GT: begin
                RegWrite = 1'b1;
                MemToReg = 2'd3;
            end
            S_R_WB_EQ: begin
                RegWrite = 1'b1;
                MemToReg = 2'd2;
            end
            S_J_EXEC: begin
                ALUSrcA = 2'd1;
                ALUSrcB = (!hi_bits && op == 4'd6) ? 2'd2 : 2'd0;
            end
            S_J_WB: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'd1;
                RegWrite = 1'b1;
            end
            S_M_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
            end
            S_M_ADDI_WB: RegWrite = 1'b1;
            S_M_LW_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_M_LW_WB: begin
                RegWrite = 1'b1;
                MemToReg = 2'd1;
            end
            S_M_SW: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_I_BNE: begin
                ALUSrcA     = 2'd1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSrc       = 2'd1;
            end
            S_I_IMM: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
            end
            S_I_WB:   RegWrite = 1'b1;
            S_TRAP: begin
                Trap    = 1'b1;
                PCWrite = 1'b1;
                PCSrc   = 2'd2;
            end
            default: ;
        endcase
    end

    assign current_state = state_q;
    assign next_state    = state_d;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: latency table, corner sequences,
// and random instruction stream against a per-opcode step-list model.
module tb_multicycle_control_fsm;

    localparam logic [7:0] B_PCW  = 8'h80;
    localparam logic [7:0] B_PCWC = 8'h40;
    localparam logic [7:0] B_IORD = 8'h20;
    localparam logic [7:0] B_IRW  = 8'h10;
    localparam logic [7:0] B_RW   = 8'h08;
    localparam logic [7:0] B_MW   = 8'h04;
    localparam logic [7:0] B_MR   = 8'h02;
    localparam logic [7:0] B_TRAP = 8'h01;

    function automatic logic [17:0] cw(input logic [7:0] f, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] u,
                                       input logic [1:0] m, input logic [1:0] p);
        return {f, a, b, u, m, p};
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    logic ready;
    logic zero;
    logic [3:0] op;
    logic [5:0] op6;

    logic pcw[3], pcwc[3], iord[3], irw[3], rw[3], mw[3], mr[3], trp[3];
    logic [1:0] sa[3], sb[3], aop[3], m2r[3], pcs[3];
    logic [4:0] cs[3], ns[3];

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .CLK(clk), .Reset(rst_n), .Opcode(op), .Zero(zero), .MemReady(ready),
        .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IorD(iord[0]), .IRWrite(irw[0]),
        .RegWrite(rw[0]), .MemWrite(mw[0]), .MemRead(mr[0]), .Trap(trp[0]),
        .ALUSrcA(sa[0]), .ALUSrcB(sb[0]), .ALUOp(aop[0]), .MemToReg(m2r[0]),
        .PCSrc(pcs[0]), .current_state(cs[0]), .next_state(ns[0])
    );

    multicycle_control_fsm #(.TRAP_EN(1'b0)) dut_nt (
        .CLK(clk), .Reset(rst_n), .Opcode(op), .Zero(zero), .MemReady(ready),
        .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IorD(iord[1]), .IRWrite(irw[1]),
        .RegWrite(rw[1]), .MemWrite(mw[1]), .MemRead(mr[1]), .Trap(trp[1]),
        .ALUSrcA(sa[1]), .ALUSrcB(sb[1]), .ALUOp(aop[1]), .MemToReg(m2r[1]),
        .PCSrc(pcs[1]), .current_state(cs[1]), .next_state(ns[1])
    );

    multicycle_control_fsm #(.OPCODE_W(6)) dut_w6 (
        .CLK(clk), .Reset(rst_n), .Opcode(op6), .Zero(zero), .MemReady(ready),
        .PCWrite(pcw[2]), .PCWriteCond(pcwc[2]), .IorD(iord[2]), .IRWrite(irw[2]),
        .RegWrite(rw[2]), .MemWrite(mw[2]), .MemRead(mr[2]), .Trap(trp[2]),
        .ALUSrcA(sa[2]), .ALUSrcB(sb[2]), .ALUOp(aop[2]), .MemToReg(m2r[2]),
        .PCSrc(pcs[2]), .current_state(cs[2]), .next_state(ns[2])
    );

    function automatic logic [17:0] got(input int i);
        return {pcw[i], pcwc[i], iord[i], irw[i], rw[i], mw[i], mr[i], trp[i],
                sa[i], sb[i], aop[i], m2r[i], pcs[i]};
    endfunction

    logic [17:0] F0, F1, RWB, GT, EQ, JWB, JAL, ADDR, ADDI, LWRD, LWWB, SW;
    logic [17:0] BNE, TRAPW, RADD, RSUB, JALR, IIMM, IWB;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: each opcode is a list of control words after FETCH.
    logic [17:0] s_cw[6];
    bit          s_wait[6];
    int          s_len;

    task automatic build(input logic [3:0] o);
        s_cw[0] = F0; s_wait[0] = 1'b1;
        s_cw[1] = '0; s_wait[1] = 1'b0;
        for (int k = 2; k < 6; k++) begin
            s_cw[k] = '0;
            s_wait[k] = 1'b0;
        end
        s_len = 4;
        case (o)
            4'd0:        begin s_cw[2] = RADD; s_cw[3] = RWB; end
            4'd1:        begin s_cw[2] = RSUB; s_cw[3] = GT; end
            4'd2:        begin s_cw[2] = RSUB; s_cw[3] = RWB; end
            4'd3:        begin s_cw[2] = RSUB; s_cw[3] = EQ; end
            4'd4:        begin s_cw[2] = JALR; s_cw[3] = JWB; end
            4'd6:        begin s_cw[2] = JAL;  s_cw[3] = JWB; end
            4'd5, 4'd15: begin s_cw[2] = IIMM; s_cw[3] = IWB; end
            4'd8:        begin s_cw[2] = ADDR; s_cw[3] = ADDI; end
            4'd9: begin
                s_cw[2] = ADDR; s_cw[3] = LWRD; s_wait[3] = 1'b1;
                s_cw[4] = LWWB; s_len = 5;
            end
            4'd10: begin s_cw[2] = ADDR; s_cw[3] = SW; s_wait[3] = 1'b1; end
            4'd11: begin s_cw[2] = BNE; s_len = 3; end
            default: begin s_cw[2] = TRAPW; s_len = 3; end
        endcase
    endtask

    typedef struct {
        logic [3:0]  op;
        int          cycles;
        logic [17:0] last;
    } vec_t;

    vec_t tbl[10];

    initial begin
        F0    = cw(B_MR, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0);
        F1    = cw(B_MR | B_PCW | B_IRW, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0);
        RADD  = cw(8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        RSUB  = cw(8'h00, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0);
        RWB   = cw(B_RW, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        GT    = cw(B_RW, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0);
        EQ    = cw(B_RW, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0);
        JALR  = cw(8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        JAL   = cw(8'h00, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0);
        JWB   = cw(B_PCW | B_RW, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1);
        ADDR  = cw(8'h00, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0);
        ADDI  = cw(B_RW, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        LWRD  = cw(B_IORD | B_MR, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        LWWB  = cw(B_RW, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0);
        SW    = cw(B_IORD | B_MW, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        BNE   = cw(B_PCWC, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1);
        IIMM  = cw(8'h00, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
        IWB   = cw(B_RW, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        TRAPW = cw(B_TRAP | B_PCW, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2);

        tbl[0] = '{4'd0,  4, RWB};
        tbl[1] = '{4'd1,  4, GT};
        tbl[2] = '{4'd3,  4, EQ};
        tbl[3] = '{4'd6,  4, JWB};
        tbl[4] = '{4'd8,  4, ADDI};
        tbl[5] = '{4'd9,  5, LWWB};
        tbl[6] = '{4'd10, 4, SW};
        tbl[7] = '{4'd11, 3, BNE};
        tbl[8] = '{4'd5,  4, IWB};
        tbl[9] = '{4'd12, 3, TRAPW};

        rst_n = 1'b0; ready = 1'b1; zero = 1'b0; op = 4'd0; op6 = 6'd0;
        @(negedge clk);
        #1 chk("reset_fetch_ready", got(0), F1);
        ready = 1'b0;
        #1 chk("reset_fetch_idle", got(0), F0);
        rst_n = 1'b1;
        tick;

        // Latency table with MemReady tied high.
        foreach (tbl[i]) begin
            int c;
            logic [17:0] last, now;
            do_reset;
            op = tbl[i].op; ready = 1'b1;
            last = '0;
            c = 1;
            while (c < 12) begin
                #1 now = got(0);
                if (c > 1 && now === F1) break;
                last = now;
                tick;
                c++;
            end
            chk_int($sformatf("latency_op%0d", tbl[i].op), c - 1, tbl[i].cycles);
            chk($sformatf("last_op%0d", tbl[i].op), last, tbl[i].last);
            tick;
        end

        // Reset while a store is stalled.
        do_reset;
        op = 4'd10; ready = 1'b1;
        tick; tick; tick;
        ready = 1'b0;
        #1 chk("sw_stall", got(0), SW);
        rst_n = 1'b0;
        #1 chk("sw_async_reset", got(0), F0);
        rst_n = 1'b1;
        #1 chk("sw_reset_release", got(0), F0);
        tick;
        #1 chk("fetch_hold", got(0), F0);

        // Load with three wait cycles.
        do_reset;
        op = 4'd9; ready = 1'b1;
        tick; tick; tick;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("lw_wait", got(0), LWRD);
            tick;
        end
        ready = 1'b1;
        #1 chk("lw_done", got(0), LWRD);
        tick;
        #1 chk("lw_wb", got(0), LWWB);
        tick;
        #1 chk("lw_next_fetch", got(0), F1);

        // BNE for both Zero values.
        for (int z = 0; z < 2; z++) begin
            do_reset;
            op = 4'd11; ready = 1'b1; zero = z[0];
            tick; tick;
            #1 chk("bne_exec", got(0), BNE);
            tick;
            #1 chk("bne_to_fetch", got(0), F1);
        end

        // Illegal opcode with and without trap.
        do_reset;
        op = 4'd7; ready = 1'b1;
        tick;
        #1 chk("nt_decode", got(1), '0);
        tick;
        #1 chk("trap_cycle", got(0), TRAPW);
        chk("nt_back_fetch", got(1), F1);
        tick;
        #1 chk("trap_one_cycle", got(0), F1);

        // Wide opcode: upper bits make it illegal.
        do_reset;
        op6 = 6'h18; ready = 1'b1;
        tick; tick;
        #1 chk("w6_illegal", got(2), TRAPW);
        do_reset;
        op6 = 6'h06;
        tick; tick;
        #1 chk("w6_jal", got(2), JAL);
        op6 = 6'h00;

        // Random instruction stream with random memory stalls.
        do_reset;
        for (int n = 0; n < 250; n++) begin
            int idx;
            logic [17:0] exp;
            op = 4'($urandom_range(0, 15));
            build(op);
            idx = 0;
            while (idx < s_len) begin
                ready = ($urandom_range(0, 3) != 0);
                zero = 1'($urandom);
                #1;
                exp = s_cw[idx];
                if (idx == 0 && ready) exp = F1;
                chk($sformatf("rand_op%0d_step%0d", op, idx), got(0), exp);
                if (!(s_wait[idx] && !ready)) idx++;
                tick;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
